// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: GPR write-back arbiter with WAW busy scoreboard; bypass outputs under GPR_WB_CTRL_BYPASS_EN
module gpr_wb_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
`ifdef GPR_WB_CTRL_BYPASS_EN
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data,
`endif
  output logic                  gpr_wen,
  output logic [ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata
);
  localparam int N = 2**ADDR_WIDTH;
  logic [N-1:0]          busy_q, busy_d, clr, set;
  logic                  gpr_wen_q, gpr_wen_d, acc, fwd1, fwd2;
  logic [ADDR_WIDTH-1:0] gpr_waddr_q, gpr_waddr_d, wb_rd;
  logic [DATA_WIDTH-1:0] gpr_wdata_q, gpr_wdata_d, wb_data;
  always_comb begin
    lsu_ready   = 1'b1;
    exu_ready   = !lsu_valid;
    issue_ready = rst || issue_rd == '0 || !busy_q[issue_rd];
    // clear-then-set so a same-edge reservation of the written index survives
    clr         = gpr_wen_q ? N'(1) << gpr_waddr_q : '0;
    set         = (issue_valid && issue_ready && issue_rd != '0) ? N'(1) << issue_rd : '0;
    busy_d      = ((busy_q & ~clr) | set) & ~N'(1);
    acc         = lsu_valid || exu_valid;
    wb_rd       = lsu_valid ? lsu_rd : exu_rd;
    wb_data     = lsu_valid ? lsu_data : exu_data;
    gpr_wen_d   = acc && wb_rd != '0;
    gpr_waddr_d = acc ? wb_rd : gpr_waddr_q;
    gpr_wdata_d = acc ? wb_data : gpr_wdata_q;
    fwd1        = gpr_wen_q && gpr_waddr_q == rs1 && rs1 != '0;
    fwd2        = gpr_wen_q && gpr_waddr_q == rs2 && rs2 != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      gpr_wen_q   <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
    end else begin
      busy_q      <= busy_d;
      gpr_wen_q   <= gpr_wen_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
    end
  end
  assign gpr_wen   = gpr_wen_q;
  assign gpr_waddr = gpr_waddr_q;
  assign gpr_wdata = gpr_wdata_q;
`ifdef GPR_WB_CTRL_BYPASS_EN
  assign rs1_fwd      = fwd1;
  assign rs2_fwd      = fwd2;
  assign rs1_fwd_data = gpr_wdata_q;
  assign rs2_fwd_data = gpr_wdata_q;
  assign rs1_busy     = busy_q[rs1] && !fwd1;
  assign rs2_busy     = busy_q[rs2] && !fwd2;
`else
  assign rs1_busy     = busy_q[rs1] && !(fwd1 && 1'b0);
  assign rs2_busy     = busy_q[rs2] && !(fwd2 && 1'b0);
`endif
endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// tb_gpr_wb_ctrl: directed table, reset sequence and randomized model check for gpr_wb_ctrl
module tb_gpr_wb_ctrl;
`ifdef GPR_WB_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic exu_valid = 0, exu_ready, lsu_valid = 0, lsu_ready, issue_valid = 0, issue_ready;
  logic [3:0] exu_rd = 0, lsu_rd = 0, issue_rd = 0, rs1 = 0, rs2 = 0, gpr_waddr;
  logic [31:0] exu_data = 0, lsu_data = 0, gpr_wdata;
  logic rs1_busy, rs2_busy, gpr_wen;
`ifdef GPR_WB_CTRL_BYPASS_EN
  logic rs1_fwd, rs2_fwd;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  gpr_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef GPR_WB_CTRL_BYPASS_EN
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata)
  );

  typedef struct {
    logic iv; logic [3:0] ird;
    logic ev; logic [3:0] erd; logic [31:0] ed;
    logic lv; logic [3:0] lrd; logic [31:0] ld;
    logic [3:0] r1;
    logic x_ir, x_er, x_rb, x_wen; logic [3:0] x_wa; logic [31:0] x_wd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [3:0] ird, logic ev, logic [3:0] erd, logic [31:0] ed,
                              logic lv, logic [3:0] lrd, logic [31:0] ld, logic [3:0] r1,
                              logic x_ir, logic x_er, logic x_rb, logic x_wen, logic [3:0] x_wa, logic [31:0] x_wd);
    vec_t v;
    v.iv = iv; v.ird = ird; v.ev = ev; v.erd = erd; v.ed = ed; v.lv = lv; v.lrd = lrd; v.ld = ld; v.r1 = r1;
    v.x_ir = x_ir; v.x_er = x_er; v.x_rb = x_rb; v.x_wen = x_wen; v.x_wa = x_wa; v.x_wd = x_wd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    issue_valid = 0; exu_valid = 0; lsu_valid = 0; issue_rd = 0; exu_rd = 0; lsu_rd = 0;
  endtask

  bit mb[16];
  logic mw; logic [3:0] ma; logic [31:0] md;
  logic exp_ir, exp_b1, exp_b2;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", gpr_wen, 0);
    chk("rst_waddr", gpr_waddr, 0);
    chk("rst_wdata", gpr_wdata, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_rs1_busy", rs1_busy, 0);
    rst = 0;
    //        iv ird ev erd ed        lv lrd ld     r1  ir er rb                wen wa  wd
    tbl.push_back(mk(1, 5, 0, 0, 0,        0, 0, 0,     5,  1, 1, 0,                0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 32'h1234, 0, 0, 0,     5,  1, 1, 1,                1, 5, 32'h1234));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0,     5,  1, 1, BYP ? 1'b0 : 1'b1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0,     5,  1, 1, 0,                0, 0, 0));
    tbl.push_back(mk(1, 7, 0, 0, 0,        0, 0, 0,     7,  1, 1, 0,                0, 0, 0));
    tbl.push_back(mk(1, 7, 1, 7, 32'h77,   0, 0, 0,     7,  0, 1, 1,                1, 7, 32'h77));
    tbl.push_back(mk(1, 7, 0, 0, 0,        0, 0, 0,     7,  0, 1, BYP ? 1'b0 : 1'b1, 0, 0, 0));
    tbl.push_back(mk(0, 7, 0, 0, 0,        0, 0, 0,     7,  1, 1, 0,                0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 32'hAA,   1, 4, 32'hBB, 0, 1, 0, 0,                1, 4, 32'hBB));
    tbl.push_back(mk(0, 0, 1, 3, 32'hAA,   0, 0, 0,     0,  1, 1, 0,                1, 3, 32'hAA));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0,     0,  1, 1, 0,                0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'hFFFF, 0, 0, 0,     0,  1, 1, 0,                0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 9, 32'h99,   0, 0, 0,     9,  1, 1, 0,                1, 9, 32'h99));
    tbl.push_back(mk(1, 9, 0, 0, 0,        0, 0, 0,     9,  1, 1, 0,                0, 0, 0));
    tbl.push_back(mk(0, 9, 0, 0, 0,        0, 0, 0,     9,  0, 1, 1,                0, 0, 0));
    foreach (tbl[i]) begin
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
      exu_valid = tbl[i].ev; exu_rd = tbl[i].erd; exu_data = tbl[i].ed;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      rs1 = tbl[i].r1; rs2 = tbl[i].r1;
      #1;
      chk($sformatf("t%0d_issue_ready", i), issue_ready, tbl[i].x_ir);
      chk($sformatf("t%0d_exu_ready", i), exu_ready, tbl[i].x_er);
      chk($sformatf("t%0d_rs1_busy", i), rs1_busy, tbl[i].x_rb);
      chk($sformatf("t%0d_rs2_busy", i), rs2_busy, tbl[i].x_rb);
      @(posedge clk); #1;
      chk($sformatf("t%0d_wen", i), gpr_wen, tbl[i].x_wen);
      if (tbl[i].x_wen) begin
        chk($sformatf("t%0d_waddr", i), gpr_waddr, tbl[i].x_wa);
        chk($sformatf("t%0d_wdata", i), gpr_wdata, tbl[i].x_wd);
      end
    end
    // reset with busy bits set and a write to x2 pending in the output stage
    idle(); issue_valid = 1; issue_rd = 2;
    @(posedge clk); #1;
    idle(); exu_valid = 1; exu_rd = 2; exu_data = 32'h22;
    @(posedge clk); #1;
    chk("pre_rst_wen", gpr_wen, 1);
    rs1 = 2;
    chk("pre_rst_rs1_busy", rs1_busy, BYP ? 0 : 1);
`ifdef GPR_WB_CTRL_BYPASS_EN
    chk("fwd_rs1", rs1_fwd, 1);
    chk("fwd_rs1_data", rs1_fwd_data, 32'h22);
`endif
    idle(); rst = 1; issue_rd = 9; exu_valid = 1; exu_rd = 6; exu_data = 32'h66;
    #1;
    chk("in_rst_issue_ready", issue_ready, 1);
    @(posedge clk); #1;
    rst = 0; idle(); issue_rd = 2;
    #1;
    chk("post_rst_wen", gpr_wen, 0);
    chk("post_rst_waddr", gpr_waddr, 0);
    chk("post_rst_issue_ready", issue_ready, 1);
    for (int r = 0; r < 16; r++) begin
      rs1 = 4'(r); #1;
      chk($sformatf("post_rst_busy%0d", r), rs1_busy, 0);
    end
    @(posedge clk); #1;
    chk("post_rst_no_write", gpr_wen, 0);
    // randomized run against a scoreboard model; state is clean after the reset above
    foreach (mb[k]) mb[k] = 0;
    mw = 0; ma = 0; md = 0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      issue_valid = $urandom_range(0, 1); issue_rd = 4'($urandom_range(0, 7));
      exu_valid = $urandom_range(0, 1); exu_rd = 4'($urandom_range(0, 7)); exu_data = $urandom;
      lsu_valid = ($urandom_range(0, 2) == 0); lsu_rd = 4'($urandom_range(0, 7)); lsu_data = $urandom;
      rs1 = 4'($urandom_range(0, 15)); rs2 = 4'($urandom_range(0, 7));
      #1;
      exp_ir = rst || issue_rd == 0 || !mb[issue_rd];
      exp_b1 = mb[rs1] && !(BYP && mw && ma == rs1 && rs1 != 0);
      exp_b2 = mb[rs2] && !(BYP && mw && ma == rs2 && rs2 != 0);
      chk("r_issue_ready", issue_ready, exp_ir);
      chk("r_exu_ready", exu_ready, !lsu_valid);
      chk("r_lsu_ready", lsu_ready, 1);
      chk("r_rs1_busy", rs1_busy, exp_b1);
      chk("r_rs2_busy", rs2_busy, exp_b2);
`ifdef GPR_WB_CTRL_BYPASS_EN
      chk("r_rs1_fwd", rs1_fwd, mw && ma == rs1 && rs1 != 0);
`endif
      if (rst) begin
        foreach (mb[k]) mb[k] = 0;
        mw = 0; ma = 0; md = 0;
      end else begin
        if (mw) mb[ma] = 0;
        if (issue_valid && exp_ir && issue_rd != 0) mb[issue_rd] = 1;
        if (lsu_valid) begin mw = lsu_rd != 0; ma = lsu_rd; md = lsu_data; end
        else if (exu_valid) begin mw = exu_rd != 0; ma = exu_rd; md = exu_data; end
        else mw = 0;
      end
      @(posedge clk); #1;
      chk("r_wen", gpr_wen, mw);
      if (mw || rst) begin
        chk("r_waddr", gpr_waddr, ma);
        chk("r_wdata", gpr_wdata, md);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
